// File: rtl/escalonador_bombas.sv
// escalonador_bombas: arbitrates a shared motor power feed between two tank
// pump controllers. At most one motor is enabled at a time. Ties are broken
// round-robin, every grant has a minimum on-time, a running motor yields to a
// waiting pump after a maximum on-time, a dead time separates grants, and
// alarms latch a fault until the operator acknowledges it.
//
// Optional feature: define ESCALONADOR_WATCHDOG_EN to add a run-length
// watchdog (parameter T_LIMITE). It forces a fault when a motor stays on for
// T_LIMITE cycles, which catches a stuck full-tank sensor.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   pedido_b1  motor request from pump 1 controller
//   pedido_b2  motor request from pump 2 controller
//   alarme_b1  sensor-fault alarm from pump 1 controller
//   alarme_b2  sensor-fault alarm from pump 2 controller
//   reconhece  operator fault acknowledge (level)
//   m1_en      motor 1 enable (registered)
//   m2_en      motor 2 enable (registered)
//   falha      latched fault indicator (registered)
//   estado     current state code, debug (registered)
module escalonador_bombas #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned T_MIN_LIGADO = 8,
    parameter int unsigned T_MAX_LIGADO = 64,
    parameter int unsigned T_PAUSA      = 4
`ifdef ESCALONADOR_WATCHDOG_EN
    ,
    parameter int unsigned T_LIMITE     = 200
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pedido_b1,
    input  logic       pedido_b2,
    input  logic       alarme_b1,
    input  logic       alarme_b2,
    input  logic       reconhece,
    output logic       m1_en,
    output logic       m2_en,
    output logic       falha,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        LIGADA_B1 = 3'd1,
        LIGADA_B2 = 3'd2,
        PAUSA     = 3'd3,
        FALHA     = 3'd4
    } estado_t;

    estado_t          st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_sat;
    // ultimo=1: pump 1 wins the next tie (reset value); ultimo=0: pump 2 wins.
    logic             ultimo, ultimo_nx;
    logic             alarme, own, other;

`ifdef ESCALONADOR_WATCHDOG_EN
    localparam int unsigned WD_W = (T_LIMITE > 2) ? $clog2(T_LIMITE) : 1;
    logic [WD_W-1:0] wd, wd_nx;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= OCIOSO;
            cnt    <= '0;
            ultimo <= 1'b1;
            m1_en  <= 1'b0;
            m2_en  <= 1'b0;
            falha  <= 1'b0;
`ifdef ESCALONADOR_WATCHDOG_EN
            wd     <= '0;
`endif
        end else begin
            st     <= st_nx;
            cnt    <= cnt_nx;
            ultimo <= ultimo_nx;
            m1_en  <= (st_nx == LIGADA_B1);
            m2_en  <= (st_nx == LIGADA_B2);
            falha  <= (st_nx == FALHA);
`ifdef ESCALONADOR_WATCHDOG_EN
            wd     <= wd_nx;
`endif
        end
    end

    assign estado = st;

    // Next-state and counter logic; alarms override every other transition.
    always_comb begin
        st_nx     = st;
        cnt_nx    = cnt;
        ultimo_nx = ultimo;
`ifdef ESCALONADOR_WATCHDOG_EN
        wd_nx     = wd;
`endif
        alarme  = alarme_b1 | alarme_b2;
        own     = (st == LIGADA_B1) ? pedido_b1 : pedido_b2;
        other   = (st == LIGADA_B1) ? pedido_b2 : pedido_b1;
        cnt_sat = (cnt == '1) ? cnt : cnt + CNT_W'(1);

        case (st)
            OCIOSO: begin
                if (alarme) begin
                    st_nx  = FALHA;
                    cnt_nx = '0;
                end else if (pedido_b1 && (!pedido_b2 || ultimo)) begin
                    st_nx     = LIGADA_B1;
                    cnt_nx    = '0;
                    ultimo_nx = 1'b0;
`ifdef ESCALONADOR_WATCHDOG_EN
                    wd_nx     = '0;
`endif
                end else if (pedido_b2) begin
                    st_nx     = LIGADA_B2;
                    cnt_nx    = '0;
                    ultimo_nx = 1'b1;
`ifdef ESCALONADOR_WATCHDOG_EN
                    wd_nx     = '0;
`endif
                end
            end
            LIGADA_B1, LIGADA_B2: begin
                if (alarme) begin
                    st_nx  = FALHA;
                    cnt_nx = '0;
                end
`ifdef ESCALONADOR_WATCHDOG_EN
                else if (wd == WD_W'(T_LIMITE - 1)) begin
                    st_nx  = FALHA;
                    cnt_nx = '0;
                end
`endif
                else if (!own && (cnt >= CNT_W'(T_MIN_LIGADO - 1))) begin
                    st_nx  = PAUSA;
                    cnt_nx = '0;
                end else if (own && other && (cnt >= CNT_W'(T_MAX_LIGADO - 1))) begin
                    st_nx  = PAUSA;
                    cnt_nx = '0;
`ifdef ESCALONADOR_WATCHDOG_EN
                    wd_nx  = '0;
`endif
                end else begin
                    cnt_nx = cnt_sat;
`ifdef ESCALONADOR_WATCHDOG_EN
                    wd_nx  = wd + WD_W'(1);
`endif
                end
            end
            PAUSA: begin
                if (alarme) begin
                    st_nx  = FALHA;
                    cnt_nx = '0;
                end else if (cnt == CNT_W'(T_PAUSA - 1)) begin
                    st_nx  = OCIOSO;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt_sat;
                end
            end
            FALHA: begin
                // Acknowledge only counts once both alarms have cleared.
                if (reconhece && !alarme) begin
                    st_nx  = PAUSA;
                    cnt_nx = '0;
                end
            end
            default: begin
                st_nx  = FALHA;
                cnt_nx = '0;
            end
        endcase
    end

endmodule
